// File: rtl/sd_rx_packer_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_rx_packer_fifo_pkg
// Brief    : Shared constants for the SD receive packer/FIFO: lane-mode
//            encodings and default geometry.
// Revision : 1.0 - initial release
// ============================================================================
package sd_rx_packer_fifo_pkg;

    // Lane-mode encoding held in the packer mode register
    typedef enum logic {
        MODE_1BIT = 1'b0,
        MODE_WIDE = 1'b1
    } lane_mode_e;

    localparam int C_DEF_DEPTH  = 16;
    localparam int C_DEF_WORD_W = 32;
    localparam int C_DEF_DIN_W  = 4;

endpackage : sd_rx_packer_fifo_pkg
`default_nettype wire

// File: rtl/sd_rx_packer_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : sd_fifo_ram
// Brief    : FIFO storage array. Synchronous write, asynchronous read, no
//            reset on the array so it maps onto distributed RAM.
// Revision : 1.0 - initial release
// ============================================================================
module sd_fifo_ram #(
    parameter  int WORD_W = 32,
    parameter  int DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    // Write port: one word per enabled edge
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so the head word falls through
    assign rdata = r_mem[raddr];

endmodule : sd_fifo_ram
`default_nettype wire

// File: rtl/sd_rx_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sd_rx_packer_fifo
// Brief    : Packs 1-bit or DIN_W-bit SD data-line beats into WORD_W-bit
//            words (either byte order) and buffers them in a first-word-
//            fall-through FIFO with level, almost-full and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module sd_rx_packer_fifo
    import sd_rx_packer_fifo_pkg::*;
#(
    parameter  int DIN_W      = C_DEF_DIN_W,
    parameter  int WORD_W     = C_DEF_WORD_W,
    parameter  int DEPTH      = C_DEF_DEPTH,
    parameter  int BIG_ENDIAN = 1,
    parameter  int AFULL_LVL  = DEPTH - 2,
    localparam int AW         = $clog2(DEPTH),
    localparam int PW         = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wide,
    input  logic              din_vld,
    input  logic [DIN_W-1:0]  din,
    input  logic              flush,
    input  logic              rd,
    output logic [WORD_W-1:0] q,
    output logic              empty,
    output logic              full,
    output logic              afull,
    output logic [PW-1:0]     level,
    output logic              ovf
);

    localparam int C_CW = $clog2(WORD_W) + 1;

    lane_mode_e        r_mode;
    logic [C_CW-1:0]   r_cnt;
    logic [WORD_W-1:0] r_pack;
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic              r_ovf;

    lane_mode_e        w_mode;
    logic [C_CW-1:0]   w_lane_w;
    logic [C_CW-1:0]   w_bit_pos;
    logic [C_CW-1:0]   w_shift;
    logic [C_CW-1:0]   w_last_cnt;
    logic [WORD_W-1:0] w_lane_ext;
    logic [WORD_W-1:0] w_merged;
    logic              w_last;
    logic              w_push;
    logic              w_wr_en;
    logic              w_rd_en;

    // Mode in force for this beat: a new word samples wide, otherwise the latched mode
    assign w_mode     = (r_cnt == '0) ? lane_mode_e'(wide) : r_mode;
    assign w_lane_w   = (w_mode == MODE_WIDE) ? C_CW'(DIN_W) : C_CW'(1);
    assign w_bit_pos  = (w_mode == MODE_WIDE) ? C_CW'(r_cnt * C_CW'(DIN_W)) : r_cnt;
    assign w_shift    = (BIG_ENDIAN != 0) ? (C_CW'(WORD_W) - w_lane_w - w_bit_pos) : w_bit_pos;
    assign w_last_cnt = (w_mode == MODE_WIDE) ? C_CW'(WORD_W / DIN_W - 1) : C_CW'(WORD_W - 1);
    assign w_lane_ext = (w_mode == MODE_WIDE) ? WORD_W'(din) : WORD_W'(din[0]);

    // Packer contents with the current beat (if any) merged in at its lane slot
    assign w_merged = din_vld ? (r_pack | (w_lane_ext << w_shift)) : r_pack;

    assign w_last  = din_vld && (r_cnt == w_last_cnt);
    assign w_push  = w_last || (flush && ((r_cnt != '0) || din_vld));
    assign w_rd_en = rd && !empty;
    assign w_wr_en = w_push && (!full || rd);

    // Packer: accumulate beats, clear on every push whether or not the FIFO took it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_1BIT;
            r_cnt  <= '0;
            r_pack <= '0;
        end else if (clr) begin
            r_mode <= MODE_1BIT;
            r_cnt  <= '0;
            r_pack <= '0;
        end else begin
            if (din_vld && (r_cnt == '0)) begin
                r_mode <= lane_mode_e'(wide);
            end
            if (w_push) begin
                r_cnt  <= '0;
                r_pack <= '0;
            end else if (din_vld) begin
                r_cnt  <= r_cnt + C_CW'(1);
                r_pack <= w_merged;
            end
        end
    end

    // FIFO pointers and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_wr_en) begin
                r_ovf <= 1'b1;
            end
        end
    end

    sd_fifo_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (w_wr_en),
        .waddr  (r_wptr[AW-1:0]),
        .wdata  (w_merged),
        .raddr  (r_rptr[AW-1:0]),
        .rdata  (q)
    );

    // Status decode from registered pointers only
    assign level = r_wptr - r_rptr;
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign afull = (level >= PW'(AFULL_LVL));
    assign ovf   = r_ovf;

endmodule : sd_rx_packer_fifo
`default_nettype wire

// File: tb/tb_sd_rx_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_rx_packer_fifo
// Brief    : Directed + randomized bench; a big-endian and a little-endian
//            instance (DEPTH=4) share one stimulus stream and are checked
//            every cycle against a beat-list / queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_rx_packer_fifo;

    localparam int DEPTH = 4;
    localparam int AFULL = DEPTH - 2;

    logic        clk = 1'b0;
    logic        rst_n, clr, wide, din_vld, flush, rd;
    logic [3:0]  din;

    logic [31:0] q_be, q_le;
    logic        empty_be, full_be, afull_be, ovf_be;
    logic        empty_le, full_le, afull_le, ovf_le;
    logic [2:0]  level_be, level_le;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0]  m_beats[$];
    int          m_L = 1;
    logic [31:0] m_qbe[$];
    logic [31:0] m_qle[$];
    logic        m_ovf = 1'b0;
    int          m_pushes = 0;

    always #5 clk = ~clk;

    sd_rx_packer_fifo #(.DIN_W(4), .WORD_W(32), .DEPTH(DEPTH), .BIG_ENDIAN(1), .AFULL_LVL(AFULL)) u_be (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wide(wide), .din_vld(din_vld), .din(din),
        .flush(flush), .rd(rd), .q(q_be), .empty(empty_be), .full(full_be),
        .afull(afull_be), .level(level_be), .ovf(ovf_be)
    );

    sd_rx_packer_fifo #(.DIN_W(4), .WORD_W(32), .DEPTH(DEPTH), .BIG_ENDIAN(0), .AFULL_LVL(AFULL)) u_le (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wide(wide), .din_vld(din_vld), .din(din),
        .flush(flush), .rd(rd), .q(q_le), .empty(empty_le), .full(full_le),
        .afull(afull_le), .level(level_le), .ovf(ovf_le)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_beats.delete();
        m_qbe.delete();
        m_qle.delete();
        m_ovf = 1'b0;
        m_L   = 1;
    endtask

    // Word assembly from the beat list: first beat is most significant (BE) or least (LE)
    function automatic logic [31:0] build(input bit be);
        logic [31:0] acc = '0;
        int n = m_beats.size();
        if (be) begin
            for (int i = 0; i < n; i++) acc = (acc << m_L) | 32'(m_beats[i]);
            acc = acc << (32 - m_L * n);
        end else begin
            for (int i = n - 1; i >= 0; i--) acc = (acc << m_L) | 32'(m_beats[i]);
        end
        return acc;
    endfunction

    task automatic model_edge();
        bit push;
        if (clr) begin
            model_reset();
            return;
        end
        if (m_beats.size() == 0) m_L = wide ? 4 : 1;
        if (din_vld) m_beats.push_back(m_L == 4 ? din : {3'b000, din[0]});
        push = (din_vld && m_beats.size() == 32 / m_L) || (flush && m_beats.size() > 0);
        if (rd && m_qbe.size() > 0) begin
            void'(m_qbe.pop_front());
            void'(m_qle.pop_front());
        end
        if (push) begin
            m_pushes++;
            if (m_qbe.size() < DEPTH) begin
                m_qbe.push_back(build(1'b1));
                m_qle.push_back(build(1'b0));
            end else begin
                m_ovf = 1'b1;
            end
            m_beats.delete();
        end
    endtask

    task automatic check_all();
        int lv = m_qbe.size();
        chk("empty_be", 32'(empty_be), 32'(lv == 0));
        chk("full_be",  32'(full_be),  32'(lv == DEPTH));
        chk("afull_be", 32'(afull_be), 32'(lv >= AFULL));
        chk("level_be", 32'(level_be), 32'(lv));
        chk("ovf_be",   32'(ovf_be),   32'(m_ovf));
        chk("level_le", 32'(level_le), 32'(lv));
        chk("ovf_le",   32'(ovf_le),   32'(m_ovf));
        chk("empty_le", 32'(empty_le), 32'(lv == 0));
        if (lv > 0) begin
            chk("q_be", q_be, m_qbe[0]);
            chk("q_le", q_le, m_qle[0]);
        end
    endtask

    task automatic step(input logic w, input logic v, input logic [3:0] d,
                        input logic f, input logic r, input logic c);
        wide = w; din_vld = v; din = d; flush = f; rd = r; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        wide = 1'b0; din_vld = 1'b0; din = '0; flush = 1'b0; rd = 1'b0; clr = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_word8(input logic [31:0] w);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, w[31 - 4*i -: 4], 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] pat;
        int cyc;

        rst_n = 1'b0; clr = 1'b0; wide = 1'b0; din_vld = 1'b0; din = '0; flush = 1'b0; rd = 1'b0;
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        idle();

        // 4-bit mode, nibbles 1..8
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        chk("nib_be", q_be, 32'h12345678);
        chk("nib_le", q_le, 32'h87654321);
        chk("nib_lvl", 32'(level_be), 32'd1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // 1-bit mode, 0xA5A5A5A5 MSB first, wide toggled from beat 10 on
        pat = 32'hA5A5A5A5;
        for (int i = 0; i < 32; i++)
            step((i >= 10), 1'b1, {3'b111, pat[31 - i]}, 1'b0, 1'b0, 1'b0);
        chk("bit_be", q_be, 32'hA5A5A5A5);
        chk("bit_le", q_le, 32'hA5A5A5A5);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Partial word with flush, then a fresh full word
        step(1'b1, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("flush_be", q_be, 32'hABC00000);
        chk("flush_le", q_le, 32'h00000CBA);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);   // flush with nothing pending: no-op
        chk("flush_nop", 32'(level_be), 32'd1);
        push_word8(32'hDEADBEEF);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        chk("fresh_be", q_be, 32'hDEADBEEF);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Overflow: five words, no reads
        for (int w = 1; w <= 5; w++) push_word8(32'h1111_1111 * w);
        chk("ovf_full", 32'(full_be), 32'd1);
        chk("ovf_set", 32'(ovf_be), 32'd1);
        for (int w = 1; w <= 4; w++) begin
            chk("ovf_rd", q_be, 32'h1111_1111 * w);
            step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        end
        chk("ovf_drained", 32'(empty_be), 32'd1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1);    // clr
        chk("clr_ovf", 32'(ovf_be), 32'd0);

        // Same with rd during the 5th push
        for (int w = 1; w <= 4; w++) push_word8(32'h2222_2222 * w);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        chk("rdpush_ovf", 32'(ovf_be), 32'd0);
        chk("rdpush_lvl", 32'(level_be), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        pulse_reset();

        // Reset mid-word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        push_word8(32'hCAFE0123);
        idle();
        chk("post_rst_be", q_be, 32'hCAFE0123);
        chk("post_rst_lvl", 32'(level_be), 32'd1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

        // Randomized stream of 2*DEPTH+3 words with random read gaps
        m_pushes = 0;
        cyc = 0;
        while ((m_pushes < 2*DEPTH + 3 || m_qbe.size() > 0) && cyc < 20000) begin
            if (m_pushes < 2*DEPTH + 3)
                step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 4'($urandom),
                     $urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1, 1'b0);
            else
                step(1'b0, 1'b0, 4'h0, 1'b0, $urandom_range(0, 1) == 1, 1'b0);
            cyc++;
        end
        chk("stream_done", 32'(m_qbe.size() == 0 && m_pushes >= 2*DEPTH + 3), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sd_rx_packer_fifo
`default_nettype wire
